timing_violation_monitor: RTL and testbench
===========================================

Name: timing_violation_monitor

Overview:
- Downstream consumer of a timing-checked flip-flop's notifier outputs (setup and hold notifier registers).
- Detects each notifier toggle and classifies it as setup, hold or both.
- Keeps saturating per-type counts and queues timestamped events in a small FIFO for a bench or readout stage.
- Also provides a single "no violations" status bit, replacing ad-hoc X-checks on the notifier.

Parameters:
- TS_W, 16: width of the free-running cycle timestamp.
- CNT_W, 8: width of each saturating violation counter.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, input, 1: single clock; every register updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- setup_flag, input, 1: setup notifier level; any 0↔1 change is one setup event.
- hold_flag, input, 1: hold notifier level; any 0↔1 change is one hold event.
- clr, input, 1: synchronous clear of the counters and the overflow flag only; the FIFO is untouched.
- rd_valid, output, 1: FIFO head entry is valid.
- rd_ready, input, 1: consumer accepts the head entry.
- rd_type, output, 2: head entry type; bit0 = setup, bit1 = hold.
- rd_ts, output, TS_W: timestamp of the head entry.
- setup_cnt, output, CNT_W: saturating count of setup events.
- hold_cnt, output, CNT_W: saturating count of hold events.
- overflow, output, 1: sticky; an event was dropped because the FIFO was full.
- fifo_count, output, clog2(DEPTH)+1: number of occupied FIFO entries.
- no_violation, output, 1: high when setup_cnt == 0, hold_cnt == 0 and overflow == 0.

Behaviour:
- Reset (rst = 1 at an edge):
  - setup_cnt, hold_cnt, overflow, fifo_count, rd_valid, the timestamp counter and the FIFO pointers go to 0; no_violation goes to 1.
  - Each flag has a 3-stage pipeline (s1, s2, s3). On reset all three stages load the current flag value, so a flag that is already at 1 does not produce a spurious event.
  - Reset mid-operation discards queued and in-flight events.
- Timestamp counter:
  - Increments by 1 every non-reset edge and wraps from 2^TS_W−1 to 0.
  - An event's timestamp is the counter's pre-edge value at its capture edge.
- Event detection:
  - s1 samples the flag, s2 <= s1, s3 <= s2.
  - A setup event is s2 ^ s3 on the setup pipeline; the hold event is the same on the hold pipeline.
  - A flag change first sampled at edge N is captured at edge N+2: the counters update and the FIFO write occurs at that edge.
  - Multiple toggles faster than 1 per cycle may merge; this is not an error.
- Simultaneous setup and hold event in the same cycle:
  - One FIFO entry is written with rd_type = 2'b11.
  - Both counters increment.
- Counters:
  - Each increments by 1 per event and saturates at 2^CNT_W−1 (no wrap).
  - clr wins over a same-cycle increment: the counter reads 0 afterwards.
  - rst has priority over clr.
- FIFO:
  - Standard valid/ready interface. A pop occurs on an edge where rd_valid && rd_ready.
  - rd_type and rd_ts are stable while rd_valid is high and no pop occurs.
  - When rd_valid = 0, rd_type and rd_ts are don't-care.
  - Push on an event when the FIFO is not full.
  - Full and event with no pop in the same cycle: the event is dropped, overflow is set, and the counters still increment.
  - Full and event with a pop in the same cycle: both happen, and fifo_count stays at DEPTH.
  - Empty and event: rd_valid = 1 after the capture edge; no bypass.
  - Pointers wrap modulo DEPTH.
- no_violation is combinational from the registered counters and overflow.
- The block has no internal state machine beyond the pipelines, counters and FIFO.

Test Plan:
- Flags at 0, rst held for 2 cycles then released, no events for 20 cycles -> setup_cnt = 0, hold_cnt = 0, rd_valid = 0, no_violation = 1.
- setup_flag toggled 0→1 just before edge N (timestamp counter = 10 at edge N) -> at edge N+2: setup_cnt = 1, rd_valid = 1, rd_type = 01, rd_ts = 12; no_violation = 0.
- setup_flag and hold_flag toggled in the same cycle -> a single entry with rd_type = 11; setup_cnt and hold_cnt each 1; fifo_count = 1.
- rd_ready = 0 and 6 hold toggles spaced 3 cycles apart -> fifo_count = 4, overflow = 1, hold_cnt = 6. Then hold rd_ready = 1 -> 4 pops with ascending rd_ts, then rd_valid = 0.
- FIFO full, with a pop and a new event in the same cycle -> fifo_count stays 4, overflow stays 0, and the new entry appears at the tail.
- setup_flag driven to 1 during rst, then 300 setup toggles, then clr; separately, rst asserted while fifo_count = 3:
  - no event on reset release;
  - setup_cnt saturates at 255;
  - after clr: counters = 0, overflow = 0, fifo_count unchanged;
  - after the mid-operation rst: fifo_count = 0 and rd_valid = 0.

Source files
------------

// File: rtl/timing_violation_monitor.sv
// rtl/timing_violation_monitor.sv - notifier toggle detector with saturating counts and timestamped event FIFO
module timing_violation_monitor #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     setup_flag,
  input  logic                     hold_flag,
  input  logic                     clr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [1:0]               rd_type,
  output logic [TS_W-1:0]          rd_ts,
  output logic [CNT_W-1:0]         setup_cnt,
  output logic [CNT_W-1:0]         hold_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     no_violation
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Pipelines hold {s3, s2, s1}; s1 is the raw sample of the notifier level.
  logic [2:0]       setup_pipe_q, setup_pipe_d;
  logic [2:0]       hold_pipe_q, hold_pipe_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TS_W+1:0]  mem_q [DEPTH];
  logic [TS_W+1:0]  mem_d [DEPTH];

  logic setup_ev, hold_ev, ev, pop, push, drop, full;

  always_comb begin
    setup_ev = setup_pipe_q[1] ^ setup_pipe_q[2];
    hold_ev  = hold_pipe_q[1] ^ hold_pipe_q[2];
    ev       = setup_ev | hold_ev;
    full     = (count_q == FULL_CNT);
    pop      = (count_q != '0) && rd_ready;
    // A pop frees the head slot, so a full FIFO can still accept this edge's event.
    push     = ev && (!full || pop);
    drop     = ev && full && !pop;

    setup_pipe_d = {setup_pipe_q[1:0], setup_flag};
    hold_pipe_d  = {hold_pipe_q[1:0], hold_flag};
    ts_d         = ts_q + TS_W'(1);

    setup_cnt_d = setup_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    ovf_d       = ovf_q | drop;
    if (setup_ev && setup_cnt_q != CNT_MAX) setup_cnt_d = setup_cnt_q + CNT_W'(1);
    if (hold_ev && hold_cnt_q != CNT_MAX)   hold_cnt_d  = hold_cnt_q + CNT_W'(1);
    if (clr) begin
      setup_cnt_d = '0;
      hold_cnt_d  = '0;
      ovf_d       = 1'b0;
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {hold_ev, setup_ev, ts_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Preload with the current level so a notifier already high does not look like a toggle.
      setup_pipe_q <= {3{setup_flag}};
      hold_pipe_q  <= {3{hold_flag}};
      ts_q         <= '0;
      setup_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      setup_pipe_q <= setup_pipe_d;
      hold_pipe_q  <= hold_pipe_d;
      ts_q         <= ts_d;
      setup_cnt_q  <= setup_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

  assign rd_valid     = (count_q != '0);
  assign rd_type      = mem_q[rd_ptr_q][TS_W+1:TS_W];
  assign rd_ts        = mem_q[rd_ptr_q][TS_W-1:0];
  assign setup_cnt    = setup_cnt_q;
  assign hold_cnt     = hold_cnt_q;
  assign overflow     = ovf_q;
  assign fifo_count   = count_q;
  assign no_violation = (setup_cnt_q == '0) && (hold_cnt_q == '0) && !ovf_q;

endmodule

// File: tb/tb_timing_violation_monitor.sv
// tb/tb_timing_violation_monitor.sv - scoreboard bench with reference model for timing_violation_monitor
module tb_timing_violation_monitor;
  localparam int TS_W  = 16;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, setup_flag = 1'b0, hold_flag = 1'b0, clr = 1'b0, rd_ready = 1'b0;
  logic             rd_valid, overflow, no_violation;
  logic [1:0]       rd_type;
  logic [TS_W-1:0]  rd_ts;
  logic [CNT_W-1:0] setup_cnt, hold_cnt;
  logic [2:0]       fifo_count;

  timing_violation_monitor #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .setup_flag(setup_flag), .hold_flag(hold_flag), .clr(clr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type), .rd_ts(rd_ts),
    .setup_cnt(setup_cnt), .hold_cnt(hold_cnt), .overflow(overflow),
    .fifo_count(fifo_count), .no_violation(no_violation)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: flag level seen at each edge, expected queue contents and counts.
  logic [17:0] sq[$];
  bit          hs[int];
  bit          hh[int];
  int          cyc = 0;
  int          mts = 0, mcount = 0, msetup = 0, mhold = 0;
  bit          movf = 1'b0;
  logic        cur_s = 1'b0, cur_h = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got rd_valid=1 expected no entry (t=%0t)", $time);
        end else begin
          e = sq.pop_front();
          chk("rd_type", int'(rd_type), int'(e[17:16]));
          chk("rd_ts", int'(rd_ts), int'(e[15:0]));
        end
      end
    end
  end

  task automatic model(input logic r, s, h, c, rdy);
    bit se, he, pop, push, drop;
    if (r) begin
      mts = 0; mcount = 0; msetup = 0; mhold = 0; movf = 1'b0;
      sq.delete();
      hs[cyc] = s; hs[cyc-1] = s; hs[cyc-2] = s;
      hh[cyc] = h; hh[cyc-1] = h; hh[cyc-2] = h;
    end else begin
      hs[cyc] = s;
      hh[cyc] = h;
      // A level change first seen at edge k is reported at edge k+2.
      se   = hs[cyc-2] != hs[cyc-3];
      he   = hh[cyc-2] != hh[cyc-3];
      pop  = rdy && (mcount > 0);
      push = (se || he) && ((mcount < DEPTH) || pop);
      drop = (se || he) && !push;
      if (push) sq.push_back({he, se, 16'(mts)});
      if (c) begin
        msetup = 0; mhold = 0; movf = 1'b0;
      end else begin
        if (se && msetup < 255) msetup++;
        if (he && mhold < 255) mhold++;
        if (drop) movf = 1'b1;
      end
      mcount = mcount + int'(push) - int'(pop);
      mts = (mts + 1) % 65536;
    end
    cyc++;
  endtask

  task automatic step(input logic r, s, h, c, rdy);
    rst = r; setup_flag = s; hold_flag = h; clr = c; rd_ready = rdy;
    @(posedge clk);
    #1;
    model(r, s, h, c, rdy);
    chk("setup_cnt", int'(setup_cnt), msetup);
    chk("hold_cnt", int'(hold_cnt), mhold);
    chk("overflow", int'(overflow), int'(movf));
    chk("fifo_count", int'(fifo_count), mcount);
    chk("rd_valid", int'(rd_valid), int'(mcount > 0));
    chk("no_violation", int'(no_violation), int'(msetup == 0 && mhold == 0 && !movf));
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, cur_s, cur_h, 1'b0, rdy);
  endtask

  initial begin
    // Reset and quiet period
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    // Single setup toggle
    cur_s = 1'b1;
    idle(5, 1'b0);
    // Simultaneous setup and hold
    cur_s = 1'b0; cur_h = 1'b1;
    idle(4, 1'b0);
    idle(3, 1'b1);
    // Overflow: six hold toggles with no consumer, then drain
    for (int i = 0; i < 6; i++) begin
      cur_h = ~cur_h;
      idle(3, 1'b0);
    end
    idle(8, 1'b1);
    step(1'b0, cur_s, cur_h, 1'b1, 1'b0);
    // Fill to full, then pop and capture on the same edge
    for (int i = 0; i < 4; i++) begin
      cur_h = ~cur_h;
      idle(2, 1'b0);
    end
    idle(3, 1'b0);
    cur_s = ~cur_s;
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(8, 1'b1);
    // Flag already high through reset, then saturate the setup counter
    cur_s = 1'b1;
    repeat (2) step(1'b1, cur_s, cur_h, 1'b0, 1'b0);
    idle(4, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cur_s = ~cur_s;
      idle(2, 1'b1);
    end
    idle(4, 1'b1);
    // Overflow then clr: FIFO contents must survive
    for (int i = 0; i < 6; i++) begin
      cur_h = ~cur_h;
      idle(2, 1'b0);
    end
    idle(3, 1'b0);
    step(1'b0, cur_s, cur_h, 1'b1, 1'b0);
    idle(6, 1'b1);
    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      cur_h = ~cur_h;
      idle(2, 1'b0);
    end
    idle(2, 1'b0);
    step(1'b1, cur_s, cur_h, 1'b0, 1'b0);
    idle(4, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, c, rdy;
      if ($urandom_range(0, 3) == 0) cur_s = ~cur_s;
      if ($urandom_range(0, 4) == 0) cur_h = ~cur_h;
      c   = ($urandom_range(0, 63) == 0);
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, cur_s, cur_h, c, rdy);
    end
    idle(10, 1'b1);
    chk("queue_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
